// File: rtl/pe_group_sched_pkg.sv
// Shared definitions for the PE_Group tile scheduler: phase encoding
// reported on the Phase port and the scheduler FSM state type.
package pe_group_sched_pkg;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_LOAD_W = 2'd1;
    localparam logic [1:0] PH_STREAM = 2'd2;
    localparam logic [1:0] PH_DRAIN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } schedState_t;

endpackage

// File: rtl/pe_group_sched_bcast_track.sv
// Broadcasts one source beat to a set of enabled lanes. Each lane is
// offered the beat until it accepts; the taken mask stops a lane from
// seeing the same beat twice. The source is released only once every
// enabled lane has accepted (now or earlier).
module bcast_track #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_valid,
    input  logic [N-1:0] enable,
    input  logic [N-1:0] grp_rdy,
    output logic         src_rdy,
    output logic [N-1:0] grp_valid,
    output logic         beat_done
);

    logic [N-1:0] takenReg;

    // An all-zero enable means the phase is inactive, so the source is held off.
    assign grp_valid = {N{src_valid}} & enable & ~takenReg;
    assign src_rdy   = (|enable) & (&(takenReg | grp_rdy | ~enable));
    assign beat_done = src_valid & src_rdy;

    // Track lanes that already took the current beat; clear on beat completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            takenReg <= '0;
        end else if (beat_done) begin
            takenReg <= '0;
        end else begin
            takenReg <= takenReg | (grp_valid & grp_rdy);
        end
    end

endmodule

// File: rtl/pe_group_sched.sv
// Tile scheduler for one PE_Group: per tile it loads one weight beat per
// PE row, streams NumPass input beats to all lanes, then drains NumPass
// output beats, repeating for NumTile tiles.
module pe_group_sched
    import pe_group_sched_pkg::*;
#(
    parameter int W_PEGroupSize = 4,
    parameter int O_PEGroupSize = 4,
    parameter int CntWidth      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  Start,
    input  logic [CntWidth-1:0]                   Cfg_NumTile,
    input  logic [CntWidth-1:0]                   Cfg_NumPass,
    output logic                                  Busy,
    output logic                                  Done,
    output logic [1:0]                            Phase,
    output logic [((O_PEGroupSize > 1) ? $clog2(O_PEGroupSize) : 1)-1:0] W_RowSel,
    output logic [CntWidth-1:0]                   TileIdx,
    input  logic                                  W_SrcValid,
    output logic                                  W_SrcRdy,
    input  logic                                  I_SrcValid,
    output logic                                  I_SrcRdy,
    output logic                                  O_SnkValid,
    input  logic                                  O_SnkRdy,
    output logic [W_PEGroupSize*O_PEGroupSize-1:0] W_GrpValid,
    input  logic [W_PEGroupSize*O_PEGroupSize-1:0] W_GrpRdy,
    output logic [W_PEGroupSize*O_PEGroupSize-1:0] I_GrpValid,
    input  logic [W_PEGroupSize*O_PEGroupSize-1:0] I_GrpRdy,
    input  logic [W_PEGroupSize*O_PEGroupSize-1:0] O_GrpValid,
    output logic [W_PEGroupSize*O_PEGroupSize-1:0] O_GrpRdy
);

    localparam int NPE  = W_PEGroupSize * O_PEGroupSize;
    localparam int RowW = (O_PEGroupSize > 1) ? $clog2(O_PEGroupSize) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(O_PEGroupSize - 1);

    schedState_t         stateReg;
    logic [CntWidth-1:0] numTileReg;
    logic [CntWidth-1:0] numPassReg;
    logic [CntWidth-1:0] beatCnt;
    logic [NPE-1:0]      wEnable;
    logic [NPE-1:0]      iEnable;
    logic                wBeat;
    logic                iBeat;
    logic                oBeat;
    logic                lastPass;
    logic                lastTile;

    // Weight beats go only to the lanes of the currently selected PE row.
    genvar gi;
    generate
        for (gi = 0; gi < NPE; gi++) begin : g_wEnable
            assign wEnable[gi] = (stateReg == ST_LOAD_W) &&
                                 (W_RowSel == RowW'(gi / W_PEGroupSize));
        end
    endgenerate

    assign iEnable = {NPE{stateReg == ST_STREAM}};

    bcast_track #(.N(NPE)) u_wTrack (
        .clk       (clk),
        .rst       (rst),
        .src_valid (W_SrcValid),
        .enable    (wEnable),
        .grp_rdy   (W_GrpRdy),
        .src_rdy   (W_SrcRdy),
        .grp_valid (W_GrpValid),
        .beat_done (wBeat)
    );

    bcast_track #(.N(NPE)) u_iTrack (
        .clk       (clk),
        .rst       (rst),
        .src_valid (I_SrcValid),
        .enable    (iEnable),
        .grp_rdy   (I_GrpRdy),
        .src_rdy   (I_SrcRdy),
        .grp_valid (I_GrpValid),
        .beat_done (iBeat)
    );

    // Output drain pops all lanes together, only when every lane has data.
    assign O_SnkValid = (stateReg == ST_DRAIN) & (&O_GrpValid);
    assign O_GrpRdy   = {NPE{O_SnkRdy & O_SnkValid}};
    assign oBeat      = O_SnkValid & O_SnkRdy;

    assign lastPass = (beatCnt == numPassReg - CntWidth'(1));
    assign lastTile = (TileIdx == numTileReg - CntWidth'(1));

    // Scheduler FSM; all status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= ST_IDLE;
            numTileReg <= '0;
            numPassReg <= '0;
            beatCnt    <= '0;
            W_RowSel   <= '0;
            TileIdx    <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Phase      <= PH_IDLE;
        end else begin
            Done <= 1'b0;
            unique case (stateReg)
                ST_IDLE: begin
                    if (Start) begin
                        // Zero-sized configs run as a single tile / pass.
                        numTileReg <= (Cfg_NumTile == '0) ? CntWidth'(1) : Cfg_NumTile;
                        numPassReg <= (Cfg_NumPass == '0) ? CntWidth'(1) : Cfg_NumPass;
                        beatCnt    <= '0;
                        W_RowSel   <= '0;
                        TileIdx    <= '0;
                        Busy       <= 1'b1;
                        Phase      <= PH_LOAD_W;
                        stateReg   <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (wBeat) begin
                        if (W_RowSel == LastRow) begin
                            W_RowSel <= '0;
                            Phase    <= PH_STREAM;
                            stateReg <= ST_STREAM;
                        end else begin
                            W_RowSel <= W_RowSel + RowW'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (iBeat) begin
                        if (lastPass) begin
                            beatCnt  <= '0;
                            Phase    <= PH_DRAIN;
                            stateReg <= ST_DRAIN;
                        end else begin
                            beatCnt <= beatCnt + CntWidth'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (oBeat) begin
                        if (lastPass) begin
                            beatCnt <= '0;
                            if (lastTile) begin
                                Busy     <= 1'b0;
                                Done     <= 1'b1;
                                Phase    <= PH_IDLE;
                                stateReg <= ST_DONE;
                            end else begin
                                TileIdx  <= TileIdx + CntWidth'(1);
                                Phase    <= PH_LOAD_W;
                                stateReg <= ST_LOAD_W;
                            end
                        end else begin
                            beatCnt <= beatCnt + CntWidth'(1);
                        end
                    end
                end
                ST_DONE: begin
                    stateReg <= ST_IDLE;
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
